// File: rtl/ifu_pkg.sv
// Shared FSM encoding and AXI response constants for the instruction prefetch unit.
package ifu_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DROP = 2'd3
  } ifu_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/ifu_prefetch_if.sv
// Prefetch unit bus: redirect input, decode-side head output, AXI4-lite read channels.
interface ifu_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) ();
  logic                     redirect_valid;
  logic [ADDR_W-1:0]        redirect_pc;
  logic                     ifu_valid;
  logic [INST_W+ADDR_W:0]   ifu_data;
  logic                     idu_ready;
  logic [ADDR_W-1:0]        ARADDR;
  logic                     ARVALID;
  logic                     ARREADY;
  logic [INST_W-1:0]        RDATA;
  logic [1:0]               RRESP;
  logic                     RVALID;
  logic                     RREADY;

  modport master (
    input  redirect_valid, redirect_pc, idu_ready, ARREADY, RDATA, RRESP, RVALID,
    output ifu_valid, ifu_data, ARADDR, ARVALID, RREADY
  );

  modport slave (
    output redirect_valid, redirect_pc, idu_ready, ARREADY, RDATA, RRESP, RVALID,
    input  ifu_valid, ifu_data, ARADDR, ARVALID, RREADY
  );
endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO holding fetched {fault, inst, pc} entries; flush beats push and pop.
// Head is shown combinationally and reads as zero while empty.
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: one outstanding AXI4-lite read, responses queued for decode.
// Redirect flushes the queue at once; an in-flight read is completed on the bus and its beat dropped.
module ifu_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input logic            clk,
  input logic            rst,
  ifu_prefetch_if.master bus
);
  import ifu_pkg::*;

  localparam int                EW        = INST_W + ADDR_W + 1;
  localparam int                CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     CNT_DEPTH = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(INST_W / 8);

  ifu_state_t        state;
  ifu_state_t        state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              pending;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              redirect;
  logic              fault;
  logic [EW-1:0]     head;

  assign redirect      = bus.redirect_valid;
  assign fault         = (bus.RRESP != AXI_RESP_OKAY);
  assign push          = (state == S_R) && bus.RVALID && !redirect && !full;
  assign pop           = bus.ifu_valid && bus.idu_ready;

  assign bus.ARVALID   = (state == S_AR);
  assign bus.RREADY    = (state == S_R) || (state == S_DROP);
  // While the address is offered it must not move, even if fetch_pc was redirected.
  assign bus.ARADDR    = (state == S_AR) ? req_pc : fetch_pc;
  assign bus.ifu_valid = !empty;
  assign bus.ifu_data  = head;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (count < CNT_DEPTH && !redirect) state_nxt = S_AR;
      S_AR:   if (bus.ARREADY) state_nxt = (pending || redirect) ? S_DROP : S_R;
      S_R: begin
        if (bus.RVALID)    state_nxt = S_IDLE;
        else if (redirect) state_nxt = S_DROP;
      end
      S_DROP: if (bus.RVALID) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      pending  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect)  fetch_pc <= bus.redirect_pc;
      else if (push) fetch_pc <= fetch_pc + PC_STEP;
      if (state == S_IDLE && state_nxt == S_AR) req_pc <= fetch_pc;
      pending <= (state == S_AR) && !bus.ARREADY && (pending || redirect);
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fault, bus.RDATA, req_pc}),
    .pop       (pop),
    .pop_data  (head),
    .flush     (redirect),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed scenarios for the prefetcher, then a randomized run against a queue-based fetch model.
module tb_ifu_prefetch;
  localparam int          ADDR_W   = 32;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  ifu_prefetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  ifu_prefetch #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.idu_ready      = 1'b0;
    bus.ARREADY        = 1'b0;
    bus.RVALID         = 1'b0;
    bus.RDATA          = '0;
    bus.RRESP          = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_ifu_valid", bus.ifu_valid, 0);
    chk("rst_arvalid", bus.ARVALID, 0);
    chk("rst_rready", bus.RREADY, 0);
    chk("rst_araddr", bus.ARADDR, RESET_PC);
    chk("rst_ifu_data", bus.ifu_data, 0);
    rst = 1'b1;
  endtask

  task automatic wait_ar(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (!bus.ARVALID && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_arvalid"}, bus.ARVALID, 1);
    chk({tag, "_araddr"}, bus.ARADDR, exp_addr);
  endtask

  task automatic serve_one(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] data, input logic [1:0] resp);
    wait_ar(tag, exp_addr);
    bus.ARREADY = 1'b1;
    tick();
    bus.ARREADY = 1'b0;
    chk({tag, "_rready"}, bus.RREADY, 1);
    bus.RVALID = 1'b1;
    bus.RDATA  = data;
    bus.RRESP  = resp;
    tick();
    bus.RVALID = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [64:0] q[$];
    logic [31:0] model_pc;
    logic [31:0] out_addr;
    logic        out_act;
    logic        out_ar_done;
    logic        out_drop;
    logic        rv;
    logic        seen;
    int          rsp_delay;
    int          idle_run;
    int          max_idle;
    int          delivered;
    int          ready_pct;

    // First fetch, response formatting and post-reset latency
    do_reset();
    tick();
    chk("t1_latency_arvalid", bus.ARVALID, 1);
    serve_one("t1", RESET_PC, 32'h0000_0413, 2'b00);
    chk("t1_ifu_valid", bus.ifu_valid, 1);
    chk("t1_ifu_data", bus.ifu_data, {1'b0, 32'h0000_0413, RESET_PC});
    wait_ar("t1_next", RESET_PC + 32'd4);

    // Back-pressure: queue fills to DEPTH, fetch stalls until a pop
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      serve_one("t2_fill", RESET_PC + 32'(4 * i), 32'h1000 + 32'(i), 2'b00);
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (bus.ARVALID) seen = 1'b1;
    end
    chk("t2_stalled", seen, 0);
    chk("t2_head", bus.ifu_data, {1'b0, 32'h0000_1000, RESET_PC});
    bus.idu_ready = 1'b1;
    tick();
    bus.idu_ready = 1'b0;
    chk("t2_head_after_pop", bus.ifu_data, {1'b0, 32'h0000_1001, RESET_PC + 32'd4});
    wait_ar("t2_resume", RESET_PC + 32'd16);

    // Redirect while the address is stalled on the bus
    do_reset();
    wait_ar("t3", RESET_PC);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (3) begin
      chk("t3_hold_arvalid", bus.ARVALID, 1);
      chk("t3_hold_araddr", bus.ARADDR, RESET_PC);
      tick();
    end
    bus.ARREADY = 1'b1;
    tick();
    bus.ARREADY = 1'b0;
    chk("t3_drop_rready", bus.RREADY, 1);
    bus.RVALID = 1'b1;
    bus.RDATA  = 32'hDEAD_BEEF;
    tick();
    bus.RVALID = 1'b0;
    chk("t3_dropped", bus.ifu_valid, 0);
    wait_ar("t3_new", 32'h8000_0100);

    // Redirect coincident with the response beat, with an older entry queued
    do_reset();
    serve_one("t4a", RESET_PC, 32'h0000_0011, 2'b00);
    chk("t4_queued", bus.ifu_valid, 1);
    wait_ar("t4b", RESET_PC + 32'd4);
    bus.ARREADY = 1'b1;
    tick();
    bus.ARREADY        = 1'b0;
    bus.RVALID         = 1'b1;
    bus.RDATA          = 32'h0000_0022;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    tick();
    bus.RVALID         = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("t4_flushed", bus.ifu_valid, 0);
    chk("t4_rready_low", bus.RREADY, 0);
    wait_ar("t4_new", 32'h8000_0200);

    // Error response is delivered as a faulting entry and fetch carries on
    do_reset();
    bus.idu_ready = 1'b1;
    serve_one("t5a", RESET_PC, 32'h0000_0a0a, 2'b00);
    serve_one("t5b", RESET_PC + 32'd4, 32'h0000_0b0b, 2'b00);
    serve_one("t5c", RESET_PC + 32'd8, 32'h0000_5555, 2'b10);
    chk("t5_fault_head", bus.ifu_data, {1'b1, 32'h0000_5555, RESET_PC + 32'd8});
    wait_ar("t5_next", RESET_PC + 32'd12);

    // Asynchronous reset in the middle of a read
    do_reset();
    wait_ar("t6", RESET_PC);
    bus.ARREADY = 1'b1;
    tick();
    bus.ARREADY = 1'b0;
    chk("t6_in_r", bus.RREADY, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_arvalid", bus.ARVALID, 0);
    chk("t6_rst_rready", bus.RREADY, 0);
    tick();
    rst = 1'b1;
    chk("t6_araddr_after", bus.ARADDR, RESET_PC);
    chk("t6_empty_after", bus.ifu_valid, 0);
    wait_ar("t6_reissue", RESET_PC);

    // Randomized traffic against the fetch-stream model
    do_reset();
    q.delete();
    model_pc    = RESET_PC;
    out_addr    = '0;
    out_act     = 1'b0;
    out_ar_done = 1'b0;
    out_drop    = 1'b0;
    rv          = 1'b0;
    rsp_delay   = 0;
    idle_run    = 0;
    max_idle    = 0;
    delivered   = 0;
    ready_pct   = 5;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) ready_pct = $urandom_range(1, 10);

      chk("rnd_valid", bus.ifu_valid, q.size() != 0);
      if (q.size() != 0) chk("rnd_data", bus.ifu_data, q[0]);
      chk("rnd_rready", bus.RREADY, out_act && out_ar_done);
      if (bus.ARVALID) begin
        if (!out_act) begin
          out_act     = 1'b1;
          out_ar_done = 1'b0;
          out_drop    = 1'b0;
          out_addr    = model_pc;
          chk("rnd_room", q.size() < DEPTH, 1);
        end
        chk("rnd_araddr", bus.ARADDR, out_addr);
        chk("rnd_ar_once", out_ar_done, 0);
        idle_run = 0;
      end else if (!out_act && q.size() < DEPTH) begin
        idle_run++;
        if (idle_run > max_idle) max_idle = idle_run;
      end else begin
        idle_run = 0;
      end

      bus.idu_ready      = ($urandom_range(1, 10) <= ready_pct);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = $urandom & 32'hFFFF_FFFC;
      bus.ARREADY        = ($urandom_range(0, 2) != 0);
      if (!rv && out_act && out_ar_done) begin
        if (rsp_delay == 0) begin
          rv        = 1'b1;
          bus.RDATA = $urandom;
          bus.RRESP = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end else begin
          rsp_delay--;
        end
      end
      bus.RVALID = rv;

      if (q.size() != 0 && bus.idu_ready) void'(q.pop_front());
      if (bus.ARVALID && bus.ARREADY) begin
        out_ar_done = 1'b1;
        rsp_delay   = $urandom_range(0, 3);
      end
      if (rv) begin
        if (!out_drop && !bus.redirect_valid) begin
          q.push_back({bus.RRESP != 2'b00, bus.RDATA, out_addr});
          model_pc = out_addr + 32'd4;
          delivered++;
        end
        out_act = 1'b0;
        rv      = 1'b0;
      end
      if (bus.redirect_valid) begin
        q.delete();
        model_pc = bus.redirect_pc;
        if (out_act) out_drop = 1'b1;
      end
      tick();
    end
    idle_inputs();
    chk("rnd_progress", delivered > 100, 1);
    chk("rnd_issue_gap", max_idle <= 8, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Param ADDR_W, 32, PC/address width.
REQ-002 Param INST_W, 32, instruction width (AXI RDATA width).
REQ-003 Param DEPTH, 4, prefetch FIFO entries (power of two, >=2).
REQ-004 Param RESET_PC, 32'h8000_0000, first fetch address.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 redirect_valid  in  1  flush and restart fetch at redirect_pc.
REQ-008 redirect_pc  in  ADDR_W  new fetch address.
REQ-009 ifu_valid  out  1  FIFO head valid.
REQ-010 ifu_data  out  INST_W+ADDR_W+1  {fault, inst, pc} of head.
REQ-011 idu_ready  in  1  consumer accepts head.
REQ-012 ARADDR  out  ADDR_W; ARVALID  out  1; ARREADY  in  1  AXI4-lite read address.
REQ-013 RDATA  in  INST_W; RRESP  in  2; RVALID  in  1; RREADY  out  1  AXI4-lite read data.

Function
REQ-014 FSM states S_IDLE, S_AR, S_R, S_DROP; one outstanding read max.
REQ-015 ARVALID SHALL equal (state==S_AR); RREADY SHALL equal (state==S_R or S_DROP).
REQ-016 S_IDLE->S_AR when count + 0 < DEPTH and no redirect this cycle; ARADDR = fetch_pc, held stable in S_AR.
REQ-017 S_AR->S_R on ARREADY (no redirect); S_AR->S_DROP on ARREADY with redirect pending.
REQ-018 S_R on RVALID: push {RRESP!=0, RDATA, req_pc} into FIFO, fetch_pc += INST_W/8 (mod 2^ADDR_W), ->S_IDLE.
REQ-019 Issue SHALL occur only if FIFO has a free slot for the response (count < DEPTH at issue).
REQ-020 ifu_valid = FIFO non-empty; ifu_data = head entry, stable while ifu_valid & !idu_ready.
REQ-021 Pop on ifu_valid & idu_ready; push and pop same cycle SHALL keep count unchanged.
REQ-022 Redirect: FIFO flushed same edge, fetch_pc <= redirect_pc, ifu_valid low next cycle.
REQ-023 Redirect in S_AR without ARREADY: ARVALID/ARADDR held (AXI stability), pending flag set; handshake completes ->S_DROP.
REQ-024 Redirect in S_R: ->S_DROP; if RVALID same cycle, beat discarded, ->S_IDLE.
REQ-025 S_DROP: beat discarded on RVALID, ->S_IDLE; later redirects only update fetch_pc.
REQ-026 Redirect concurrent with pop or push: flush wins, no entry survives.
REQ-027 Fault (RRESP!=0) entry delivered normally; fetch continues sequentially.
REQ-028 Latency: ARVALID high 1 cycle after reset release; ifu_valid high 1 cycle after RVALID&RREADY.

Reset
REQ-029 On rst low (async): state S_IDLE, FIFO empty, fetch_pc=RESET_PC, pending=0.
REQ-030 Outputs during reset: ifu_valid=0, ARVALID=0, RREADY=0, ARADDR=RESET_PC, ifu_data=0.
REQ-031 Reset mid-transaction abandons it; no response accepted until next issue.

Structure
REQ-032 Package ifu_pkg holds ifu_state_t enum and AXI_RESP_OKAY constant (2'b00).
REQ-033 Sub-module fetch_fifo (params WIDTH, DEPTH; push/pop/flush, full/empty/count) holds entries.
REQ-034 Target size 150-300 RTL lines; no write channel logic.

Verification
REQ-035 Reset release, ARREADY=1, RVALID 1 cycle later, RDATA=32'h0000_0413 -> ifu_data={0,32'h0000_0413,32'h8000_0000}, next ARADDR=32'h8000_0004.
REQ-036 idu_ready=0, DEPTH=4 -> exactly 4 fetches (0x8000_0000..0x8000_000C), ARVALID stays 0 until one pop.
REQ-037 redirect_pc=32'h8000_0100 while S_AR, ARREADY low 3 cycles -> ARADDR holds old value, response dropped, next ARADDR=32'h8000_0100.
REQ-038 redirect same cycle as RVALID in S_R -> beat discarded, FIFO empty, ifu_valid=0 next cycle.
REQ-039 RRESP=2'b10 on fetch at 32'h8000_0008 -> head fault=1, next ARADDR=32'h8000_000C.
REQ-040 rst low while S_R -> ARVALID/RREADY=0 immediately, ARADDR=RESET_PC after release.
